// File: rtl/army_deploy_queue_pkg.sv
// rtl/army_deploy_queue_pkg.sv - shared game constants: army costs, cooldown reloads, scene codes
package army_deploy_queue_pkg;

  typedef logic [2:0] army_t;

  localparam int NUM_TYPES = 8;

  localparam logic [2:0] SCENE_PLAY1 = 3'd2;
  localparam logic [2:0] SCENE_PLAY2 = 3'd3;
  localparam logic [2:0] SCENE_PLAY3 = 3'd4;

  localparam logic [14:0] COST [NUM_TYPES] = '{
    15'd75, 15'd150, 15'd240, 15'd350, 15'd750, 15'd1500, 15'd2000, 15'd2400
  };

  // Reload values are in frames.
  localparam logic [4:0] CD_RELOAD [NUM_TYPES] = '{
    5'd4, 5'd6, 5'd8, 5'd10, 5'd16, 5'd20, 5'd24, 5'd31
  };

  function automatic logic is_play(input logic [2:0] s);
    return (s >= SCENE_PLAY1) && (s <= SCENE_PLAY3);
  endfunction

endpackage

// File: rtl/type_fifo.sv
// rtl/type_fifo.sv - small spawn FIFO with flush; push while full is allowed alongside a pop
module type_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                      clk_25MHz,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Storage is never reset, so the head is masked while empty.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/army_deploy_queue.sv
// rtl/army_deploy_queue.sv - click arbitration, per-type cooldowns, money debit and spawn queue
module army_deploy_queue
  import army_deploy_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CDW    = 5
) (
  input  logic                      clk_25MHz,
  input  logic                      rst_n,
  input  logic                      clk_frame_op,
  input  logic [2:0]                scene,
  input  logic                      gameInit,
  input  logic [9:0]                effectiveClick,
  input  logic [14:0]               money,
  output logic                      debit_valid,
  output logic [14:0]               debit_amount,
  output logic                      spawn_valid,
  output logic [2:0]                spawn_type,
  input  logic                      spawn_ready,
  output logic [7:0][CDW-1:0]       genArmyCD,
  output logic                      click_dropped
);

  logic                  flush;
  logic                  any_click;
  army_t                 win_type;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_req;
  logic                  can_accept;
  logic                  accept;
  logic                  reject;
  logic [$clog2(QDEPTH):0] fifo_count_unused;
  logic                  unused_click_bits;

  assign unused_click_bits = effectiveClick[9] ^ effectiveClick[0];

  assign flush = gameInit || !is_play(scene);

  // Lowest set click bit wins; the rest are ignored without a drop pulse.
  always_comb begin
    win_type  = '0;
    any_click = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (effectiveClick[i+1]) begin
        win_type  = army_t'(i);
        any_click = 1'b1;
      end
    end
  end

  assign spawn_valid = !fifo_empty;
  assign pop_req     = spawn_valid && spawn_ready;

  // debit_valid high means money has not yet reflected the last purchase.
  assign can_accept = (genArmyCD[win_type] == '0) && (!fifo_full || pop_req) &&
                      (money >= COST[win_type]) && !debit_valid;
  assign accept     = any_click && !flush && can_accept;
  assign reject     = any_click && !flush && !can_accept;

  type_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk_25MHz (clk_25MHz),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .push_data (win_type),
    .pop       (pop_req && !flush),
    .head      (spawn_type),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count_unused)
  );

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      debit_valid   <= 1'b0;
      debit_amount  <= '0;
      click_dropped <= 1'b0;
    end else if (flush) begin
      debit_valid   <= 1'b0;
      debit_amount  <= '0;
      click_dropped <= 1'b0;
    end else begin
      debit_valid   <= accept;
      debit_amount  <= accept ? COST[win_type] : '0;
      click_dropped <= reject;
    end
  end

  // A reload on accept beats a same-cycle frame decrement.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      genArmyCD <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (flush)
          genArmyCD[i] <= '0;
        else if (accept && (win_type == army_t'(i)))
          genArmyCD[i] <= CDW'(CD_RELOAD[i]);
        else if (clk_frame_op && (genArmyCD[i] != '0))
          genArmyCD[i] <= genArmyCD[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_army_deploy_queue.sv
// tb/tb_army_deploy_queue.sv - scoreboard bench for army_deploy_queue
module tb_army_deploy_queue;

  logic             clk_25MHz = 1'b0;
  logic             rst_n;
  logic             clk_frame_op;
  logic [2:0]       scene;
  logic             gameInit;
  logic [9:0]       effectiveClick;
  logic [14:0]      money;
  logic             debit_valid;
  logic [14:0]      debit_amount;
  logic             spawn_valid;
  logic [2:0]       spawn_type;
  logic             spawn_ready;
  logic [7:0][4:0]  genArmyCD;
  logic             click_dropped;

  army_deploy_queue #(.QDEPTH(4), .CDW(5)) dut (
    .clk_25MHz      (clk_25MHz),
    .rst_n          (rst_n),
    .clk_frame_op   (clk_frame_op),
    .scene          (scene),
    .gameInit       (gameInit),
    .effectiveClick (effectiveClick),
    .money          (money),
    .debit_valid    (debit_valid),
    .debit_amount   (debit_amount),
    .spawn_valid    (spawn_valid),
    .spawn_type     (spawn_type),
    .spawn_ready    (spawn_ready),
    .genArmyCD      (genArmyCD),
    .click_dropped  (click_dropped)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  ev_t exp_q[$];
  int  spawn_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_debit(input int amt);
    ev_t e;
    e.kind  = 0;
    e.value = amt;
    exp_q.push_back(e);
  endtask

  task automatic exp_drop();
    ev_t e;
    e.kind  = 1;
    e.value = 0;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [9:0] clicks, input logic frame, input logic ready, input logic ginit);
    effectiveClick = clicks;
    clk_frame_op   = frame;
    spawn_ready    = ready;
    gameInit       = ginit;
    @(posedge clk_25MHz);
    #1;
    effectiveClick = '0;
    clk_frame_op   = 1'b0;
    spawn_ready    = 1'b0;
    gameInit       = 1'b0;
  endtask

  // Monitor: pops expected events whenever the DUT presents a debit, drop or spawn handshake.
  initial begin
    forever begin
      @(negedge clk_25MHz);
      if (debit_valid === 1'b1) begin
        if (exp_q.size() > 0 && exp_q[0].kind == 0) begin
          ev_t e;
          e = exp_q.pop_front();
          check("debit_amount", int'(debit_amount), e.value);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_debit: got amount %0d expected no debit", debit_amount);
        end
      end
      if (click_dropped === 1'b1) begin
        if (exp_q.size() > 0 && exp_q[0].kind == 1) begin
          ev_t e;
          e = exp_q.pop_front();
          check("click_dropped", int'(click_dropped), 1);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_drop: got click_dropped=1 expected 0");
        end
      end
      if (spawn_valid === 1'b1 && spawn_ready === 1'b1) begin
        if (spawn_q.size() > 0) begin
          int t;
          t = spawn_q.pop_front();
          check("spawn_type", int'(spawn_type), t);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_spawn: got type %0d expected empty queue", spawn_type);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    clk_frame_op   = 1'b0;
    scene          = 3'd2;
    gameInit       = 1'b0;
    effectiveClick = '0;
    money          = '0;
    spawn_ready    = 1'b0;
    repeat (2) @(posedge clk_25MHz);
    #1;
    check("rst_spawn_valid", int'(spawn_valid), 0);
    check("rst_spawn_type", int'(spawn_type), 0);
    check("rst_debit_valid", int'(debit_valid), 0);
    check("rst_click_dropped", int'(click_dropped), 0);
    check("rst_cd_all", int'(genArmyCD), 0);
    @(negedge clk_25MHz);
    rst_n = 1'b1;
    @(posedge clk_25MHz);
    #1;

    // Basic accept
    money = 15'd100;
    exp_debit(75); spawn_q.push_back(0);
    tick(10'h002, 0, 0, 0);
    check("basic_spawn_valid", int'(spawn_valid), 1);
    check("basic_spawn_type", int'(spawn_type), 0);
    check("basic_cd0", int'(genArmyCD[0]), 4);

    // Cooldown countdown and drop while cooling
    tick(10'h000, 1, 0, 0);
    check("cd0_3", int'(genArmyCD[0]), 3);
    tick(10'h000, 1, 0, 0);
    check("cd0_2", int'(genArmyCD[0]), 2);
    exp_drop();
    tick(10'h002, 0, 0, 0);
    check("cd0_hold", int'(genArmyCD[0]), 2);
    tick(10'h000, 1, 0, 0);
    check("cd0_1", int'(genArmyCD[0]), 1);
    tick(10'h000, 1, 0, 0);
    check("cd0_0", int'(genArmyCD[0]), 0);
    tick(10'h000, 1, 0, 0);
    check("cd0_sat", int'(genArmyCD[0]), 0);
    tick(10'h000, 0, 1, 0);
    check("drained_spawn_valid", int'(spawn_valid), 0);

    // Fill to full, drop, then push with simultaneous pop
    money = 15'd9000;
    exp_debit(75);  spawn_q.push_back(0); tick(10'h002, 0, 0, 0); tick(10'h000, 0, 0, 0);
    exp_debit(150); spawn_q.push_back(1); tick(10'h004, 0, 0, 0); tick(10'h000, 0, 0, 0);
    exp_debit(240); spawn_q.push_back(2); tick(10'h008, 0, 0, 0); tick(10'h000, 0, 0, 0);
    exp_debit(350); spawn_q.push_back(3); tick(10'h010, 0, 0, 0); tick(10'h000, 0, 0, 0);
    check("full_count", int'(dut.u_fifo.count), 4);
    exp_drop();
    tick(10'h020, 0, 0, 0);
    check("full_drop_count", int'(dut.u_fifo.count), 4);
    exp_debit(750); spawn_q.push_back(4);
    tick(10'h020, 0, 1, 0);
    check("full_pushpop_count", int'(dut.u_fifo.count), 4);
    check("full_pushpop_cd4", int'(genArmyCD[4]), 16);

    // Priority and money-update hazard
    tick(10'h000, 0, 0, 1);
    spawn_q.delete();
    check("flush1_spawn_valid", int'(spawn_valid), 0);
    exp_debit(75); spawn_q.push_back(0);
    tick(10'h006, 0, 0, 0);
    exp_drop();
    tick(10'h004, 0, 0, 0);
    exp_debit(150); spawn_q.push_back(1);
    tick(10'h004, 0, 0, 0);
    check("prio_cd0", int'(genArmyCD[0]), 4);
    check("prio_cd1", int'(genArmyCD[1]), 6);
    tick(10'h000, 0, 0, 0);

    // Money boundary
    money = 15'd2399;
    exp_drop();
    tick(10'h100, 0, 0, 0);
    money = 15'd2400;
    exp_debit(2400); spawn_q.push_back(7);
    tick(10'h100, 0, 0, 0);
    check("money_cd7", int'(genArmyCD[7]), 31);
    tick(10'h000, 0, 0, 0);

    // Flush with queued entries and a running cooldown
    tick(10'h000, 0, 0, 1);
    spawn_q.delete();
    money = 15'd9000;
    exp_debit(1500); spawn_q.push_back(5);
    tick(10'h040, 0, 0, 0);
    tick(10'h000, 1, 0, 0);
    exp_debit(75); spawn_q.push_back(0);
    tick(10'h002, 1, 0, 0);
    check("reload_beats_frame_cd0", int'(genArmyCD[0]), 4);
    check("cd5_18", int'(genArmyCD[5]), 18);
    for (int i = 0; i < 6; i++) tick(10'h000, 1, 0, 0);
    check("cd5_12", int'(genArmyCD[5]), 12);
    check("cd0_sat_after", int'(genArmyCD[0]), 0);
    check("two_entries", int'(dut.u_fifo.count), 2);
    check("head_type5", int'(spawn_type), 5);
    tick(10'h004, 0, 0, 1);
    spawn_q.delete();
    check("flush2_spawn_valid", int'(spawn_valid), 0);
    check("flush2_cd_all", int'(genArmyCD), 0);

    // Reset asserted while a debit is being presented
    exp_debit(1500); spawn_q.push_back(5);
    tick(10'h040, 0, 0, 0);
    @(negedge clk_25MHz);
    #2;
    rst_n = 1'b0;
    #1;
    spawn_q.delete();
    check("rst_mid_debit_valid", int'(debit_valid), 0);
    check("rst_mid_debit_amount", int'(debit_amount), 0);
    check("rst_mid_spawn_valid", int'(spawn_valid), 0);
    check("rst_mid_cd5", int'(genArmyCD[5]), 0);
    @(posedge clk_25MHz);
    #1;
    tick(10'h000, 0, 0, 0);
    rst_n = 1'b1;
    tick(10'h000, 0, 0, 0);
    tick(10'h000, 0, 0, 0);
    check("post_rst_debit_valid", int'(debit_valid), 0);

    // Outside PLAY scenes clicks are ignored without a drop
    scene = 3'd1;
    tick(10'h002, 0, 0, 0);
    check("menu_spawn_valid", int'(spawn_valid), 0);
    check("menu_cd0", int'(genArmyCD[0]), 0);
    scene = 3'd2;
    tick(10'h000, 0, 0, 0);
    tick(10'h000, 0, 0, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/army_deploy_queue.md
ARMY_DEPLOY_QUEUE -- requirements
Module: army_deploy_queue

Interface
REQ-001 SHALL expose parameters: QDEPTH, default 4, spawn-queue entries; CDW, default 5, cooldown counter width.
REQ-002 SHALL expose ports:
- clk_25MHz  in  1  game clock; one clock only.
- rst_n  in  1  asynchronous, active-low reset.
- clk_frame_op  in  1  one-cycle frame tick.
- scene  in  3  current scene code; PLAY1..PLAY3 = 2..4.
- gameInit  in  1  level-start pulse.
- effectiveClick  in  10  click pulses; only bits [8:1] are used, bit n = army type n-1.
- money  in  15  current money.
- debit_valid  out  1  one-cycle money-deduct request.
- debit_amount  out  15  amount to deduct.
- spawn_valid  out  1  queue head valid.
- spawn_type  out  3  army type at queue head.
- spawn_ready  in  1  engine accepts the head.
- genArmyCD  out  8x5  per-type remaining cooldown.
- click_dropped  out  1  one-cycle pulse when a click is rejected by this block.

Function
REQ-003 Cost table SHALL be, for types 0..7: 75, 150, 240, 350, 750, 1500, 2000, 2400.
REQ-004 Cooldown reload table SHALL be, for types 0..7: 4, 6, 8, 10, 16, 20, 24, 31 frames.
REQ-005 Arbitration: at most one click SHALL be accepted per cycle; when several bits of [8:1] are set, the lowest index wins and the other set bits are silently ignored (no drop pulse).
REQ-006 The winning click SHALL be accepted only when all of these hold:
- scene is PLAY1..PLAY3;
- genArmyCD[type]==0;
- queue not full;
- money >= cost[type];
- no debit_valid was asserted in the previous cycle (money-update hazard).
REQ-007 Otherwise the winning click SHALL be rejected: click_dropped=1 for one cycle, no state change.
REQ-008 Accept, same edge: push type into FIFO tail; debit_valid=1 and debit_amount=cost for exactly the next cycle; genArmyCD[type] <= reload[type].
REQ-009 Each genArmyCD entry SHALL decrement by 1 on each clk_frame_op and saturate at 0.
REQ-010 On a simultaneous accept and clk_frame_op for the same type, the reload SHALL take priority (no decrement that cycle).
REQ-011 FIFO: spawn_valid=!empty; spawn_type=head entry; pop when spawn_valid && spawn_ready.
REQ-012 Push and pop in the same cycle SHALL be allowed, including when the FIFO is full: occupancy is unchanged and the click is accepted.
REQ-013 Read/write pointers SHALL wrap modulo QDEPTH; occupancy count SHALL have width clog2(QDEPTH)+1.
REQ-014 Full = count==QDEPTH; empty = count==0; pop when empty and push when full (without a simultaneous pop) SHALL never alter state.
REQ-015 Flush: gameInit=1, or scene outside PLAY1..PLAY3, SHALL on the next edge empty the FIFO, zero all genArmyCD entries, clear debit_valid, and ignore any click in that same cycle.
REQ-016 Flush SHALL have priority over accept, pop and cooldown decrement.
REQ-017 Arithmetic: money and cost compared as unsigned 15-bit; no subtraction inside the block.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear: FIFO pointers and count; all genArmyCD entries; debit_valid, debit_amount, click_dropped; the previous-debit flag.
REQ-019 After reset: spawn_valid=0; spawn_type=0; FIFO storage contents don't-care.
REQ-020 Reset asserted mid-operation SHALL discard any queued entries and any pending debit, with no partial debit emitted after release.

Structure
REQ-021 The shared game package SHALL hold: COST table, CD_RELOAD table, the scene code constants, and an army-type typedef (3-bit).
REQ-022 The FIFO SHALL be one sub-module, type_fifo (parameterised depth and width), instantiated once; arbitration, cooldown and debit logic live in army_deploy_queue.

Verification
REQ-023 Basic accept: money=100, effectiveClick=0x002, scene=2 -> next cycle debit_valid=1 with amount 75; spawn_valid=1, spawn_type=0; genArmyCD[0]=4.
REQ-024 Cooldown: after REQ-023, four clk_frame_op ticks -> genArmyCD[0] goes 3,2,1,0. A click on bit1 while at 2 -> click_dropped=1, no debit.
REQ-025 Full/drop and fill: spawn_ready=0, money=9000, accept types 0,1,2,3 on separate cycles respecting the hazard gap -> count=4. A fifth click (type 4) -> click_dropped=1. Repeat the click with spawn_ready=1 in the same cycle -> accepted, count stays 4.
REQ-026 Priority/hazard: effectiveClick=0x006 -> type 0 accepted only. Bit2 asserted alone in the immediately following cycle -> dropped. The same click one cycle later -> accepted.
REQ-027 Insufficient money: money=2399, bit8 -> dropped. money=2400 -> accepted, debit 2400.
REQ-028 Flush/reset: queue holds 2 entries, genArmyCD[5]=12. gameInit=1 -> next cycle spawn_valid=0 and all CD=0. Repeat, then drop rst_n mid-debit -> outputs zero immediately.
